tag_response_reorder_buffer: RTL and testbench
==============================================

// Module: tag_response_reorder_buffer
// PURPOSE
//  Initiator-side partner to the tag-indexed request-metadata queue.
//  - Hands out transaction tags in strict allocation order and stores per-tag request metadata.
//  - Accepts responses that return out of order, each carrying its tag.
//  - Releases responses to the client in allocation order, each paired with its metadata.
//  - Sits between the core-side memory client and the AXI4 read-response channel.
// PARAMETERS
//  TAG_W   2   tag width; DEPTH = 2**TAG_W entries
//  DATA_W  64  response payload width
//  META_W  4   request metadata width ({addr_beat[2:0], subblock})
// PORTS
//  clk               in   1       clock; all state updates on posedge
//  reset_n           in   1       asynchronous active-low reset
//  io_alloc_ready    out  1       a tag is free
//  io_alloc_valid    in   1       client requests a tag
//  io_alloc_meta     in   META_W  metadata stored with the allocated tag
//  io_alloc_tag      out  TAG_W   tag granted on alloc fire (= alloc_ptr)
//  io_resp_valid     in   1       response beat present
//  io_resp_ready     out  1       tied 1; responses are never back-pressured
//  io_resp_tag       in   TAG_W   tag of the response
//  io_resp_data      in   DATA_W  response payload
//  io_out_valid      out  1       head response available
//  io_out_ready      in   1       client accepts head
//  io_out_data       out  DATA_W  head payload
//  io_out_meta       out  META_W  head metadata
//  io_count          out  TAG_W+1 outstanding entries (allocated, not yet retired)
//  io_resp_err       out  1       registered 1-cycle pulse on a spurious response
// BEHAVIOUR
//  State: alloc_ptr, head_ptr (TAG_W, wrap mod DEPTH); count (TAG_W+1).
//  - Per entry: pending bit, done bit, meta register, data register.
//  Reset (async, reset_n=0): ptrs=0, count=0, pending=0, done=0, io_resp_err=0.
//  - Resulting outputs: io_out_valid=0, io_alloc_ready=1, io_alloc_tag=0.
//  - Data/meta arrays are not reset.
//  Allocation:
//  - io_alloc_ready = (count != DEPTH).
//  - On fire: meta[alloc_ptr]<=io_alloc_meta; pending<=1; done<=0; alloc_ptr+1.
//  - When full, alloc is blocked even if the head retires in the same cycle (no same-cycle tag reuse).
//  Response, accepted when pending[tag] & !done[tag]:
//  - data[tag]<=io_resp_data; done[tag]<=1.
//  - Any other response is dropped: no state change, io_resp_err=1 next cycle.
//  - A response whose tag is being allocated in the same cycle is spurious.
//  Output:
//  - io_out_valid = pending[head] & done[head].
//  - data/meta are read combinationally at head_ptr.
//  - Held stable while valid & !ready.
//  - On fire: pending[head]<=0; done[head]<=0; head_ptr+1.
//  - Minimum latency from the head's response to io_out_valid is 1 cycle.
//  count: +1 on alloc fire, -1 on out fire; both in the same cycle leaves it unchanged.
//  count==0: io_out_valid=0 regardless of response inputs.
// CONFIGURATION
//  CORERISCV_REORDER_BYPASS_EN defined:
//  - Condition: io_resp_valid with tag==head_ptr and pending & !done.
//  - io_out_valid asserts in the same cycle; io_out_data = io_resp_data.
//  - If io_out_ready: the entry retires directly, done is never set.
//  - Else: the response is stored normally and is presented next cycle.
//  Undefined: no bypass path; latency is always >= 1 cycle.
// TESTING
//  1 Assert reset_n=0 mid-traffic -> immediately out_valid=0, count=0, alloc_ready=1, alloc_tag=0.
//  2 Four allocs with meta 1..4 -> tags 0,1,2,3; count=4; alloc_ready=0; a 5th alloc is held.
//  3 Resps tags 2,0,3,1 with data A2,A0,A3,A1, out_ready=1:
//    - A0/meta1 emitted the cycle after tag0's response.
//    - Nothing emitted until tag1 arrives.
//    - Then A1, A2, A3 on consecutive cycles; count ends at 0.
//  4 Resp tag1 while idle; then a duplicate resp to a done tag ->
//    - io_resp_err high exactly 1 cycle each; count and data unchanged.
//  5 out_ready=0 for 5 cycles -> data/meta stable; six allocs across retires -> tags 0,1,2,3,0,1.
//  6 Head resp with out_ready=1:
//    - Bypass build: out_valid in the same cycle.
//    - Default build: out_valid 1 cycle later.

Source files
------------

// File: rtl/tag_response_reorder_buffer.sv
`default_nettype none
// ====================================================================
// Module : tag_response_reorder_buffer
// Brief  : in-order tag allocator with out-of-order response reordering;
//          optional head bypass under CORERISCV_REORDER_BYPASS_EN.
// Rev    : 1.0
// ====================================================================
module tag_response_reorder_buffer #(
  parameter int TAG_W  = 2,
  parameter int DATA_W = 64,
  parameter int META_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              io_alloc_ready,
  input  logic              io_alloc_valid,
  input  logic [META_W-1:0] io_alloc_meta,
  output logic [TAG_W-1:0]  io_alloc_tag,
  input  logic              io_resp_valid,
  output logic              io_resp_ready,
  input  logic [TAG_W-1:0]  io_resp_tag,
  input  logic [DATA_W-1:0] io_resp_data,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic [META_W-1:0] io_out_meta,
  output logic [TAG_W:0]    io_count,
  output logic              io_resp_err
);

  localparam int DEPTH = 1 << TAG_W;
  localparam logic [TAG_W:0] c_full_count = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0]  r_alloc_ptr;
  logic [TAG_W-1:0]  r_head_ptr;
  logic [TAG_W:0]    r_count;
  logic [DEPTH-1:0]  r_pending;
  logic [DEPTH-1:0]  r_done;
  logic [META_W-1:0] r_meta [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_resp_err;

  logic w_alloc_fire;
  logic w_resp_ok;
  logic w_resp_store;
  logic w_bypass;
  logic w_out_fire;

  // Readiness depends only on count, so a full buffer never reuses the
  // head's tag in the cycle it retires.
  assign io_alloc_ready = (r_count != c_full_count);
  assign w_alloc_fire   = io_alloc_valid & io_alloc_ready;

  assign w_resp_ok = io_resp_valid & r_pending[io_resp_tag] & ~r_done[io_resp_tag]
                   & ~(w_alloc_fire & (io_resp_tag == r_alloc_ptr));

`ifdef CORERISCV_REORDER_BYPASS_EN
  assign w_bypass = w_resp_ok & (io_resp_tag == r_head_ptr);
`else
  assign w_bypass = 1'b0;
`endif

  assign io_out_valid = (r_pending[r_head_ptr] & r_done[r_head_ptr]) | w_bypass;
  assign io_out_data  = w_bypass ? io_resp_data : r_data[r_head_ptr];
  assign io_out_meta  = r_meta[r_head_ptr];
  assign w_out_fire   = io_out_valid & io_out_ready;

  // A bypassed response that retires immediately never marks its entry done.
  assign w_resp_store = w_resp_ok & ~(w_bypass & io_out_ready);

  assign io_alloc_tag  = r_alloc_ptr;
  assign io_resp_ready = 1'b1;
  assign io_count      = r_count;
  assign io_resp_err   = r_resp_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_alloc_ptr <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_pending   <= '0;
      r_done      <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_resp_err <= io_resp_valid & ~w_resp_ok;
      if (w_resp_store) begin
        r_done[io_resp_tag] <= 1'b1;
      end
      if (w_alloc_fire) begin
        r_pending[r_alloc_ptr] <= 1'b1;
        r_done[r_alloc_ptr]    <= 1'b0;
        r_alloc_ptr            <= r_alloc_ptr + 1'b1;
      end
      if (w_out_fire) begin
        r_pending[r_head_ptr] <= 1'b0;
        r_done[r_head_ptr]    <= 1'b0;
        r_head_ptr            <= r_head_ptr + 1'b1;
      end
      case ({w_alloc_fire, w_out_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; validity lives in pending/done.
  always_ff @(posedge clk) begin
    if (w_alloc_fire) begin
      r_meta[r_alloc_ptr] <= io_alloc_meta;
    end
    if (w_resp_store) begin
      r_data[io_resp_tag] <= io_resp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tag_response_reorder_buffer.sv
`default_nettype none
// ====================================================================
// Module : tb_tag_response_reorder_buffer
// Brief  : directed bench with tag-order scoreboard for the reorder buffer.
// Rev    : 1.0
// ====================================================================
module tb_tag_response_reorder_buffer;
  localparam int TAG_W  = 2;
  localparam int DATA_W = 64;
  localparam int META_W = 4;
  localparam int DEPTH  = 4;
`ifdef CORERISCV_REORDER_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              alloc_ready, alloc_valid;
  logic [META_W-1:0] alloc_meta;
  logic [TAG_W-1:0]  alloc_tag;
  logic              resp_valid, resp_ready;
  logic [TAG_W-1:0]  resp_tag;
  logic [DATA_W-1:0] resp_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [META_W-1:0] out_meta;
  logic [TAG_W:0]    count;
  logic              resp_err;

  tag_response_reorder_buffer #(.TAG_W(TAG_W), .DATA_W(DATA_W), .META_W(META_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .io_alloc_ready(alloc_ready), .io_alloc_valid(alloc_valid),
    .io_alloc_meta(alloc_meta), .io_alloc_tag(alloc_tag),
    .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
    .io_resp_tag(resp_tag), .io_resp_data(resp_data),
    .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_out_data(out_data), .io_out_meta(out_meta),
    .io_count(count), .io_resp_err(resp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard: tags queued in allocation order, model of per-tag state.
  logic [TAG_W-1:0]  q_tag [$];
  logic [DATA_W-1:0] m_data [DEPTH];
  logic [META_W-1:0] m_meta [DEPTH];
  logic [DEPTH-1:0]  m_pending, m_done;
  logic [TAG_W-1:0]  m_alloc_ptr;
  logic              m_err_exp;
  int                emit_cyc [$];
  logic [DATA_W-1:0] emit_data [$];
  logic [META_W-1:0] emit_meta [$];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_tag.delete();
    m_pending   = '0;
    m_done      = '0;
    m_alloc_ptr = '0;
    m_err_exp   = 1'b0;
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [15:0] hi, input int k);
    return {hi, 48'h0} | DATA_W'(k);
  endfunction

  // One clock: compare at negedge, update the model, return at posedge+1.
  task automatic cycle();
    logic [TAG_W-1:0] h;
    logic exp_valid, accept, byp, m_ready;
    @(negedge clk);
    cyc++;
    h       = (q_tag.size() > 0) ? q_tag[0] : '0;
    m_ready = (q_tag.size() != DEPTH);
    accept  = reset_n && resp_valid && m_pending[resp_tag] && !m_done[resp_tag]
              && !(alloc_valid && m_ready && resp_tag == m_alloc_ptr);
    byp = 1'b0;
`ifdef CORERISCV_REORDER_BYPASS_EN
    byp = accept && (q_tag.size() > 0) && (resp_tag == h);
`endif
    exp_valid = ((q_tag.size() > 0) && m_pending[h] && m_done[h]) || byp;
    chk("out_valid", out_valid, exp_valid);
    chk("count", count, q_tag.size());
    chk("alloc_ready", alloc_ready, m_ready);
    chk("resp_err", resp_err, m_err_exp);
    chk("resp_ready", resp_ready, 1'b1);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (exp_valid && out_ready) begin
        chk("out_data", out_data, byp ? resp_data : m_data[h]);
        chk("out_meta", out_meta, m_meta[h]);
        emit_cyc.push_back(cyc);
        emit_data.push_back(out_data);
        emit_meta.push_back(out_meta);
        void'(q_tag.pop_front());
        m_pending[h] = 1'b0;
        m_done[h]    = 1'b0;
      end
      if (accept && !(byp && out_ready)) begin
        m_done[resp_tag] = 1'b1;
        m_data[resp_tag] = resp_data;
      end
      m_err_exp = resp_valid && !accept;
      if (alloc_valid && m_ready) begin
        chk("alloc_tag", alloc_tag, m_alloc_ptr);
        m_meta[m_alloc_ptr]    = alloc_meta;
        m_pending[m_alloc_ptr] = 1'b1;
        m_done[m_alloc_ptr]    = 1'b0;
        q_tag.push_back(m_alloc_ptr);
        m_alloc_ptr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, r0, r1;
    reset_n = 1'b0; alloc_valid = 1'b0; alloc_meta = '0;
    resp_valid = 1'b0; resp_tag = '0; resp_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_count", count, 0);
    chk("rst_resp_err", resp_err, 1'b0);
    reset_n = 1'b1;
    cycle();

    // Fill all four tags, then show a fifth request is held off.
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_meta  = META_W'(i + 1);
      #1 chk("fill_tag", alloc_tag, i);
      cycle();
    end
    alloc_meta = 4'd5;
    #1;
    chk("full_count", count, 4);
    chk("full_ready", alloc_ready, 1'b0);
    cycle();
    alloc_valid = 1'b0;

    // Out-of-order responses 2,0,3,1 released in order 0,1,2,3.
    base = emit_cyc.size();
    out_ready = 1'b1;
    resp_valid = 1'b1;
    resp_tag = 2'd2; resp_data = pat(16'hA000, 2); cycle();
    resp_tag = 2'd0; resp_data = pat(16'hA000, 0); r0 = cyc + 1; cycle();
    resp_tag = 2'd3; resp_data = pat(16'hA000, 3); cycle();
    resp_tag = 2'd1; resp_data = pat(16'hA000, 1); r1 = cyc + 1; cycle();
    resp_valid = 1'b0;
    repeat (4) cycle();
    chk("ooo_emits", emit_cyc.size() - base, 4);
    if (emit_cyc.size() - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("ooo_data", emit_data[base+k], pat(16'hA000, k));
        chk("ooo_meta", emit_meta[base+k], k + 1);
      end
      chk("ooo_lat0", emit_cyc[base], r0 + LAT);
      chk("ooo_lat1", emit_cyc[base+1], r1 + LAT);
      chk("ooo_lat2", emit_cyc[base+2], r1 + LAT + 1);
      chk("ooo_lat3", emit_cyc[base+3], r1 + LAT + 2);
    end
    chk("ooo_count_end", count, 0);

    // Spurious response while idle.
    out_ready = 1'b0;
    resp_valid = 1'b1; resp_tag = 2'd1; resp_data = pat(16'hDEAD, 1); cycle();
    resp_valid = 1'b0;
    #1 chk("idle_err_hi", resp_err, 1'b1);
    chk("idle_err_count", count, 0);
    cycle();
    #1 chk("idle_err_lo", resp_err, 1'b0);

    // Duplicate response to a done entry must not overwrite it.
    alloc_valid = 1'b1; alloc_meta = 4'd7; cycle();
    alloc_valid = 1'b0;
    resp_valid = 1'b1; resp_tag = 2'd0; resp_data = pat(16'hB000, 0); cycle();
    resp_data = pat(16'hB000, 1); cycle();
    resp_valid = 1'b0;
    #1;
    chk("dup_err_hi", resp_err, 1'b1);
    chk("dup_count", count, 1);
    chk("dup_data", out_data, pat(16'hB000, 0));
    cycle();
    #1 chk("dup_err_lo", resp_err, 1'b0);

    // Stalled head holds data and meta.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_data", out_data, pat(16'hB000, 0));
      chk("stall_meta", out_meta, 4'd7);
      cycle();
    end
    out_ready = 1'b1; cycle();
    out_ready = 1'b0;

    // Asynchronous reset with a valid head outstanding.
    alloc_valid = 1'b1; alloc_meta = 4'd3; cycle();
    alloc_meta = 4'd4; cycle();
    alloc_valid = 1'b0;
    resp_valid = 1'b1; resp_tag = 2'd1; resp_data = pat(16'hC000, 9); cycle();
    resp_valid = 1'b0;
    #1 chk("pre_rst_valid", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_count", count, 0);
    chk("arst_alloc_ready", alloc_ready, 1'b1);
    chk("arst_alloc_tag", alloc_tag, 0);
    model_reset();
    cycle();
    cycle();
    reset_n = 1'b1;
    cycle();

    // Six allocations across retirements wrap the tag space.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1'b1;
      alloc_meta  = META_W'(i + 8);
      #1 chk("wrap_tag", alloc_tag, i % 4);
      cycle();
      alloc_valid = 1'b0;
      resp_valid = 1'b1; resp_tag = TAG_W'(i % 4); resp_data = pat(16'hD000, i);
      cycle();
      resp_valid = 1'b0;
      cycle();
    end
    chk("wrap_count", count, 0);

    // Head response latency.
    alloc_valid = 1'b1; alloc_meta = 4'd9; cycle();
    alloc_valid = 1'b0;
    resp_valid = 1'b1; resp_tag = 2'd2; resp_data = pat(16'hE000, 2);
    #1 chk("head_same_cycle", out_valid, (LAT == 0) ? 1'b1 : 1'b0);
    cycle();
    resp_valid = 1'b0;
    #1 chk("head_next_cycle", out_valid, (LAT == 0) ? 1'b0 : 1'b1);
    cycle();
    #1 chk("final_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
